// File: rtl/count_ones_seq_pkg.sv
// Shared definitions for the sequential population counter: FSM state
// encodings and a constant clog2 used to size counters at elaboration.
package count_ones_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Smallest r with 2**r >= v; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(v)) begin
        r = r + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/count_ones_seq_if.sv
// Request/result bundle of the population counter. The requester drives
// start/mode/data; the counter returns ready/busy/done and the bit count.
interface count_ones_seq_if #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned COUNT_WIDTH = 4
) ();

  logic                   start;
  logic                   mode;
  logic [DATA_WIDTH-1:0]  data;
  logic                   ready;
  logic                   busy;
  logic                   done;
  logic [COUNT_WIDTH-1:0] bit_count;

  modport master (
    output start,
    output mode,
    output data,
    input  ready,
    input  busy,
    input  done,
    input  bit_count
  );

  modport slave (
    input  start,
    input  mode,
    input  data,
    output ready,
    output busy,
    output done,
    output bit_count
  );

endinterface

// File: rtl/count_ones_seq_popcount_chunk.sv
// Combinational popcount of one W-bit chunk, zero-extended to CW bits.
module popcount_chunk #(
  parameter int unsigned W  = 1,
  parameter int unsigned CW = 4
) (
  input  logic [W-1:0]  chunk_i,
  output logic [CW-1:0] count_o
);

  // Ripple sum of the chunk bits.
  always_comb begin
    count_o = '0;
    for (int unsigned i = 0; i < W; i++) begin
      count_o = count_o + CW'(chunk_i[i]);
    end
  end

endmodule

// File: rtl/count_ones_seq.sv
// Sequential population counter. A word is captured on start & ready
// (inverted when counting zeros), then consumed BITS_PER_CYCLE bits per
// clock from the LSB end. With EARLY_EXIT the walk stops as soon as the
// remaining shifted word holds no ones, since further chunks add nothing.
// DATA_WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE.
module count_ones_seq
  import count_ones_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned COUNT_WIDTH    = clog2(DATA_WIDTH + 1),
  parameter int unsigned EARLY_EXIT     = 1
) (
  input logic             clk,
  input logic             reset,
  count_ones_seq_if.slave bus
);

  localparam int unsigned NumChunks = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int unsigned ChunkCntW = (NumChunks > 1) ? clog2(NumChunks) : 1;
  localparam logic [ChunkCntW-1:0] LastChunk = ChunkCntW'(NumChunks - 1);

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
  logic [ChunkCntW-1:0]   chunk_cnt_q, chunk_cnt_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic [DATA_WIDTH-1:0]  loaded;
  logic [DATA_WIDTH-1:0]  shifted;
  logic [COUNT_WIDTH-1:0] chunk_ones;
  logic                   early_on_load;
  logic                   early_on_shift;

  // Counting zeros is counting ones of the complemented operand.
  assign loaded  = bus.mode ? ~bus.data : bus.data;
  assign shifted = shreg_q >> BITS_PER_CYCLE;

  assign early_on_load  = (EARLY_EXIT != 0) && (loaded == '0);
  assign early_on_shift = (EARLY_EXIT != 0) && (shifted == '0);

  popcount_chunk #(
    .W  (BITS_PER_CYCLE),
    .CW (COUNT_WIDTH)
  ) u_popcount_chunk (
    .chunk_i (shreg_q[BITS_PER_CYCLE-1:0]),
    .count_o (chunk_ones)
  );

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      chunk_cnt_q <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      chunk_cnt_q <= chunk_cnt_d;
      count_q     <= count_d;
    end
  end

  // Controller next state and datapath updates.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    chunk_cnt_d = chunk_cnt_q;
    count_d     = count_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          shreg_d     = loaded;
          chunk_cnt_d = '0;
          count_d     = '0;
          // Nothing to count: skip straight to the result pulse.
          state_d     = early_on_load ? S_DONE : S_COUNT;
        end
      end

      S_COUNT: begin
        count_d     = count_q + chunk_ones;
        shreg_d     = shifted;
        chunk_cnt_d = chunk_cnt_q + ChunkCntW'(1);
        if ((chunk_cnt_q == LastChunk) || early_on_shift) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // start is deliberately ignored here; ready rises next cycle.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the state register.
  assign bus.ready     = (state_q == S_IDLE);
  assign bus.busy      = (state_q == S_COUNT);
  assign bus.done      = (state_q == S_DONE);
  assign bus.bit_count = count_q;

endmodule

// File: tb/tb_count_ones_seq.sv
// Self-checking bench: three instances (8/1/early, 8/4/early, 8/1/full length).
// Expected counts and latencies come from a reference model, queued at
// accept time and popped when done is observed.
module tb_count_ones_seq;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       st [3];
  logic       md [3];
  logic [7:0] dt [3];

  int cyc    = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [3:0] cnt;
    int         k;
    int         acc;
  } exp_t;

  exp_t exp_q[$];

  count_ones_seq_if #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) if0 ();
  count_ones_seq_if #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) if1 ();
  count_ones_seq_if #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) if2 ();

  assign if0.start = st[0];
  assign if0.mode  = md[0];
  assign if0.data  = dt[0];
  assign if1.start = st[1];
  assign if1.mode  = md[1];
  assign if1.data  = dt[1];
  assign if2.start = st[2];
  assign if2.mode  = md[2];
  assign if2.data  = dt[2];

  count_ones_seq #(
    .DATA_WIDTH(8), .BITS_PER_CYCLE(1), .COUNT_WIDTH(4), .EARLY_EXIT(1)
  ) u_dut0 (.clk(clk), .reset(reset), .bus(if0));

  count_ones_seq #(
    .DATA_WIDTH(8), .BITS_PER_CYCLE(4), .COUNT_WIDTH(4), .EARLY_EXIT(1)
  ) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

  count_ones_seq #(
    .DATA_WIDTH(8), .BITS_PER_CYCLE(1), .COUNT_WIDTH(4), .EARLY_EXIT(0)
  ) u_dut2 (.clk(clk), .reset(reset), .bus(if2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic rdy(input int i);
    case (i)
      0:       return if0.ready;
      1:       return if1.ready;
      default: return if2.ready;
    endcase
  endfunction

  function automatic logic bsy(input int i);
    case (i)
      0:       return if0.busy;
      1:       return if1.busy;
      default: return if2.busy;
    endcase
  endfunction

  function automatic logic dn(input int i);
    case (i)
      0:       return if0.done;
      1:       return if1.done;
      default: return if2.done;
    endcase
  endfunction

  function automatic logic [3:0] cnt(input int i);
    case (i)
      0:       return if0.bit_count;
      1:       return if1.bit_count;
      default: return if2.bit_count;
    endcase
  endfunction

  function automatic int bpc_of(input int i);
    return (i == 1) ? 4 : 1;
  endfunction

  function automatic int ee_of(input int i);
    return (i == 2) ? 0 : 1;
  endfunction

  // Reference: count = popcount of effective word; k from highest set bit.
  function automatic exp_t model(input int idx, input logic [7:0] d, input logic m);
    logic [7:0] eff;
    int         hi;
    exp_t       e;
    eff   = m ? ~d : d;
    e.cnt = 4'd0;
    e.acc = 0;
    hi    = -1;
    for (int i = 0; i < 8; i++) begin
      if (eff[i]) begin
        e.cnt = e.cnt + 4'd1;
        hi    = i;
      end
    end
    if (ee_of(idx) != 0) e.k = (hi < 0) ? 0 : (hi / bpc_of(idx)) + 1;
    else                 e.k = 8 / bpc_of(idx);
    return e;
  endfunction

  // Present one request at a negedge; returns at the negedge after accept.
  task automatic issue(input int idx, input logic [7:0] d, input logic m);
    int   guard;
    exp_t e;
    guard = 0;
    while (!rdy(idx) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_cmp++;
      n_fail++;
      $display("FAIL issue_ready_timeout: ready stayed %b, want 1", rdy(idx));
    end
    dt[idx] = d;
    md[idx] = m;
    st[idx] = 1'b1;
    e = model(idx, d, m);
    @(negedge clk);
    st[idx] = 1'b0;
    e.acc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int idx, output bit seen, output int busy_n);
    int guard;
    guard  = 0;
    busy_n = 0;
    while (!dn(idx) && guard < 100) begin
      if (bsy(idx)) busy_n++;
      @(negedge clk);
      guard++;
    end
    seen = dn(idx);
  endtask

  // One complete operation with its checks.
  task automatic test_op(input int idx, input logic [7:0] d, input logic m, input string name);
    bit   seen;
    int   busy_n;
    int   lat;
    exp_t e;
    issue(idx, d, m);
    wait_done(idx, seen, busy_n);
    e   = exp_q.pop_front();
    lat = cyc - e.acc;
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s done_seen: got 0 want 1", name);
    end
    n_cmp++;
    if (cnt(idx) !== e.cnt) begin
      n_fail++;
      $display("FAIL %s bit_count: got %0d want %0d", name, cnt(idx), e.cnt);
    end
    n_cmp++;
    if (lat != e.k) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, e.k);
    end
    n_cmp++;
    if (busy_n != e.k) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_n, e.k);
    end
    @(negedge clk);
    n_cmp++;
    if (rdy(idx) !== 1'b1 || dn(idx) !== 1'b0 || cnt(idx) !== e.cnt) begin
      n_fail++;
      $display("FAIL %s idle_hold: ready=%b done=%b cnt=%0d want 1/0/%0d", name, rdy(idx),
               dn(idx), cnt(idx), e.cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rdy(i) !== 1'b1 || bsy(i) !== 1'b0 || dn(i) !== 1'b0 || cnt(i) !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: ready=%b busy=%b done=%b cnt=%0d want 1/0/0/0", i,
                 rdy(i), bsy(i), dn(i), cnt(i));
      end
    end
  endtask

  task automatic test_basic();
    test_op(0, 8'h0F, 1'b0, "d0F");
    test_op(0, 8'h80, 1'b0, "d80");
    test_op(0, 8'hFF, 1'b0, "dFF");
  endtask

  task automatic test_modes();
    test_op(0, 8'h00, 1'b0, "zero_ones");
    test_op(0, 8'hFF, 1'b1, "zeros_of_FF");
    test_op(0, 8'hF0, 1'b1, "zeros_of_F0");
    test_op(0, 8'h5A, 1'b1, "zeros_of_5A");
  endtask

  task automatic test_params();
    test_op(1, 8'hFF, 1'b0, "bpc4_FF");
    test_op(1, 8'h0E, 1'b0, "bpc4_0E");
    test_op(1, 8'h00, 1'b0, "bpc4_00");
    test_op(2, 8'h01, 1'b0, "full_01");
    test_op(2, 8'h00, 1'b0, "full_00");
    test_op(2, 8'hFF, 1'b1, "full_zeros_FF");
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      test_op(n % 3, 8'($urandom), 1'($urandom), "random");
    end
  endtask

  // start held high, operand changing every cycle.
  task automatic test_back_to_back();
    exp_t e;
    exp_t p;
    int   prev_acc;
    int   prev_k;
    int   lat;
    bit   have_prev;
    bit   seen;
    int   busy_n;
    have_prev = 1'b0;
    prev_acc  = 0;
    prev_k    = 0;
    st[0]     = 1'b1;
    for (int n = 0; n < 150; n++) begin
      if (dn(0) && exp_q.size() > 0) begin
        p   = exp_q.pop_front();
        lat = cyc - p.acc;
        n_cmp++;
        if (cnt(0) !== p.cnt) begin
          n_fail++;
          $display("FAIL b2b bit_count: got %0d want %0d", cnt(0), p.cnt);
        end
        n_cmp++;
        if (lat != p.k) begin
          n_fail++;
          $display("FAIL b2b latency: got %0d want %0d", lat, p.k);
        end
      end
      dt[0] = 8'($urandom);
      md[0] = 1'($urandom);
      if (rdy(0)) begin
        e     = model(0, dt[0], md[0]);
        e.acc = cyc + 1;
        if (have_prev) begin
          n_cmp++;
          if (e.acc - prev_acc != prev_k + 2) begin
            n_fail++;
            $display("FAIL b2b spacing: got %0d want %0d", e.acc - prev_acc, prev_k + 2);
          end
        end
        have_prev = 1'b1;
        prev_acc  = e.acc;
        prev_k    = e.k;
        exp_q.push_back(e);
      end
      @(negedge clk);
    end
    st[0] = 1'b0;
    while (exp_q.size() > 0) begin
      wait_done(0, seen, busy_n);
      p = exp_q.pop_front();
      n_cmp++;
      if (!seen || cnt(0) !== p.cnt || (cyc - p.acc) != p.k) begin
        n_fail++;
        $display("FAIL b2b_drain: seen=%b cnt=%0d lat=%0d want 1/%0d/%0d", seen, cnt(0),
                 cyc - p.acc, p.cnt, p.k);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    exp_t e;
    bit   got_done;
    issue(0, 8'hB5, 1'b0);
    e = exp_q.pop_front();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (rdy(0) !== 1'b1 || bsy(0) !== 1'b0 || dn(0) !== 1'b0 || cnt(0) !== 4'd0) begin
      n_fail++;
      $display("FAIL abort_state: ready=%b busy=%b done=%b cnt=%0d want 1/0/0/0 (k was %0d)",
               rdy(0), bsy(0), dn(0), cnt(0), e.k);
    end
    got_done = 1'b0;
    repeat (12) begin
      if (dn(0)) got_done = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (got_done) begin
      n_fail++;
      $display("FAIL abort_no_done: got done pulse, want none");
    end
    test_op(0, 8'hB5, 1'b0, "B5_rerun");
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      md[i] = 1'b0;
      dt[i] = 8'h00;
    end
    @(negedge clk);
    test_reset();
    test_basic();
    test_modes();
    test_back_to_back();
    test_abort();
    test_params();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
